// File: rtl/dmem_access_ctrl.sv
// Memory-stage data-memory access controller.
// Handles one load/store per instruction over a request/ready bus.
// The pipeline is stalled while the bus is busy, and load data is returned
// aligned and extended. Misaligned accesses and bus timeouts are reported.
module dmem_access_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [2:0]  funct3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic        StallM,
  output logic [31:0] ReadDataM,
  output logic        MisalignM,
  output logic        BusErrM,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit TO_EN = (TIMEOUT > 0);

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          err;
  logic [31:0]   rdata_q;
  logic [1:0]    addr_lo_q;
  logic [2:0]    size_q;

  logic          access;
  logic          is_store;
  logic          misaligned;
  logic          start;
  logic          timed_out;
  logic [31:0]   wdata_n;
  logic [3:0]    wstrb_n;
  logic [7:0]    lane_b;
  logic [15:0]   lane_h;
  logic [31:0]   ext;

  // Decode size, alignment and store lane placement from the MEM-stage inputs.
  // funct3[1:0] alone selects the size; unlisted encodings fall into the word case.
  always_comb begin
    access     = MemReadM | MemWriteM;
    is_store   = MemWriteM & ~MemReadM;
    misaligned = 1'b0;
    wstrb_n    = 4'b1111;
    wdata_n    = WriteDataM;
    case (funct3M[1:0])
      2'b00: begin
        wstrb_n = 4'b0001 << ALUResultM[1:0];
        wdata_n = {4{WriteDataM[7:0]}};
      end
      2'b01: begin
        wstrb_n    = ALUResultM[1] ? 4'b1100 : 4'b0011;
        wdata_n    = {2{WriteDataM[15:0]}};
        misaligned = ALUResultM[0];
      end
      default: misaligned = |ALUResultM[1:0];
    endcase
  end

  assign start     = (state == IDLE) & access & ~misaligned;
  assign MisalignM = (state == IDLE) & access & misaligned;
  assign StallM    = start | (state == WAIT);
  assign BusErrM   = (state == DONE) & err;
  assign timed_out = TO_EN && (cnt == CNT_LAST);

  // Select the addressed lane of the captured word and extend it.
  always_comb begin
    case (addr_lo_q)
      2'd0:    lane_b = rdata_q[7:0];
      2'd1:    lane_b = rdata_q[15:8];
      2'd2:    lane_b = rdata_q[23:16];
      default: lane_b = rdata_q[31:24];
    endcase
    lane_h = addr_lo_q[1] ? rdata_q[31:16] : rdata_q[15:0];
    case (size_q)
      3'b000:  ext = {{24{lane_b[7]}}, lane_b};
      3'b001:  ext = {{16{lane_h[15]}}, lane_h};
      3'b100:  ext = {24'd0, lane_b};
      3'b101:  ext = {16'd0, lane_h};
      default: ext = rdata_q;
    endcase
    ReadDataM = ((state == DONE) && !err) ? ext : '0;
  end

  // Access sequencing: latch the request, wait for ready or timeout, then release.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      err       <= 1'b0;
      rdata_q   <= '0;
      addr_lo_q <= '0;
      size_q    <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state     <= WAIT;
            mem_req   <= 1'b1;
            mem_we    <= is_store;
            mem_addr  <= {ALUResultM[31:2], 2'b00};
            mem_wdata <= is_store ? wdata_n : '0;
            mem_wstrb <= is_store ? wstrb_n : '0;
            addr_lo_q <= ALUResultM[1:0];
            size_q    <= funct3M;
            cnt       <= '0;
            err       <= 1'b0;
          end
        end
        WAIT: begin
          if (mem_ready) begin
            state   <= DONE;
            mem_req <= 1'b0;
            rdata_q <= mem_rdata;
          end else if (timed_out) begin
            state   <= DONE;
            mem_req <= 1'b0;
            err     <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
